// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor front end: element geometry,
// ALU opcodes, sequencer states and the flat-bus packing offset.
package coproc_pkg;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int FLAT_W = MAX_N * MAX_N * ELEM_W;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_SUM  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_OPP  = 3'd4;
    localparam logic [2:0] OP_TRN  = 3'd5;
    localparam logic [2:0] OP_SCL  = 3'd6;
    localparam logic [2:0] OP_DET  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT,
        STREAM,
        RESP
    } state_t;

    // Row stride on the flat bus is always MAX_N, independent of the active size.
    function automatic logic [7:0] elem_offset(input logic [2:0] row, input logic [2:0] col);
        return 8'((32'(row) * MAX_N + 32'(col)) * ELEM_W);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over an n x n matrix; wraps back to (0, 0)
// after the last element so the next phase starts clean.
module matrix_index_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [2:0] size,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] size_m1;

    assign size_m1 = size - 3'd1;
    assign last    = (row == size_m1) && (col == size_m1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            row <= 3'd0;
            col <= 3'd0;
        end else if (advance) begin
            if (last) begin
                row <= 3'd0;
                col <= 3'd0;
            end else if (col == size_m1) begin
                col <= 3'd0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator front end for the matrix ALU: takes a command, packs streamed
// operand bytes onto the flat buses, issues the op and streams the result back.
module alu_sequencer
    import coproc_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int DET_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_opcode,
    input  logic [2:0]   cmd_matrix_size,
    input  logic [7:0]   cmd_scalar,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         resp_valid,
    output logic         resp_overflow,
    output logic         resp_error,
    output logic [7:0]   resp_number,
    output logic         busy,
    output logic [2:0]   alu_opcode,
    output logic [2:0]   alu_matrix_size,
    output logic [199:0] alu_A_flat,
    output logic [199:0] alu_B_flat,
    output logic [7:0]   alu_scalar,
    input  logic [199:0] alu_C_flat,
    input  logic [7:0]   alu_number,
    input  logic         alu_overflow_flag,
    input  logic         alu_done
);

    localparam logic [6:0] LAT_LAST = 7'(ALU_LATENCY - 1);
    localparam logic [6:0] LAT      = 7'(ALU_LATENCY);
    localparam logic [6:0] TMO_LAST = 7'(DET_TIMEOUT - 1);

    state_t              state, state_next;
    logic [2:0]          op_r, size_r;
    logic [7:0]          scalar_r;
    logic [FLAT_W-1:0]   a_flat, b_flat, c_flat;
    logic [6:0]          wait_cnt;
    logic                ovf_r, err_r;
    logic [7:0]          num_r;

    logic                idx_adv, idx_last;
    logic [2:0]          idx_row, idx_col;
    logic [7:0]          idx_off;
    logic                cmd_bad, det_window;

    assign cmd_bad    = (cmd_opcode == OP_NONE) || (cmd_matrix_size < 3'd2) || (cmd_matrix_size > 3'd5);
    assign det_window = (wait_cnt >= LAT);
    assign idx_off    = elem_offset(idx_row, idx_col);

    matrix_index_counter u_idx (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == IDLE),
        .advance (idx_adv),
        .size    (size_r),
        .row     (idx_row),
        .col     (idx_col),
        .last    (idx_last)
    );

    always_comb begin
        state_next = state;
        idx_adv    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_next = cmd_bad ? RESP : LOAD_A;
            end
            LOAD_A: begin
                if (in_valid) begin
                    idx_adv = 1'b1;
                    if (idx_last) begin
                        case (op_r)
                            OP_SUM, OP_SUB, OP_MUL:         state_next = LOAD_B;
                            OP_OPP, OP_TRN, OP_SCL, OP_DET: state_next = ISSUE;
                            default:                        state_next = RESP;
                        endcase
                    end
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    idx_adv = 1'b1;
                    if (idx_last) state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (op_r == OP_DET) begin
                    // alu_done is ignored until the ALU could plausibly have finished.
                    if ((det_window && alu_done) || (wait_cnt == TMO_LAST)) state_next = RESP;
                end else if (wait_cnt == LAT_LAST) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    idx_adv = 1'b1;
                    if (idx_last) state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= 3'd0;
            size_r   <= 3'd0;
            scalar_r <= 8'd0;
            a_flat   <= '0;
            b_flat   <= '0;
            c_flat   <= '0;
            wait_cnt <= 7'd0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
            num_r    <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r     <= cmd_opcode;
                        size_r   <= cmd_matrix_size;
                        scalar_r <= cmd_scalar;
                        a_flat   <= '0;
                        b_flat   <= '0;
                        c_flat   <= '0;
                        ovf_r    <= 1'b0;
                        err_r    <= cmd_bad;
                        num_r    <= 8'd0;
                    end
                end
                LOAD_A: if (in_valid) a_flat[idx_off +: ELEM_W] <= in_data;
                LOAD_B: if (in_valid) b_flat[idx_off +: ELEM_W] <= in_data;
                ISSUE:  wait_cnt <= 7'd0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 7'd1;
                    if (state_next == STREAM) begin
                        c_flat <= alu_C_flat;
                        ovf_r  <= alu_overflow_flag;
                    end
                    if (op_r == OP_DET && state_next == RESP) begin
                        if (det_window && alu_done) begin
                            num_r <= alu_number;
                            ovf_r <= alu_overflow_flag;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign in_ready        = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid       = (state == STREAM);
    assign out_data        = c_flat[idx_off +: ELEM_W];
    assign out_last        = (state == STREAM) && idx_last;
    assign resp_valid      = (state == RESP);
    assign resp_overflow   = ovf_r;
    assign resp_error      = err_r;
    assign resp_number     = num_r;
    assign alu_opcode      = ((state == ISSUE) || (state == WAIT)) ? op_r : 3'd0;
    assign alu_matrix_size = size_r;
    assign alu_A_flat      = a_flat;
    assign alu_B_flat      = b_flat;
    assign alu_scalar      = scalar_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a latency-accurate behavioural ALU
// and a scoreboard of expected result bytes.
module tb_alu_sequencer;

    logic         clock = 1'b0;
    logic         reset, cmd_valid, in_valid, out_ready;
    logic [2:0]   cmd_opcode, cmd_matrix_size;
    logic [7:0]   cmd_scalar, in_data;
    logic         cmd_ready, in_ready, out_valid, out_last;
    logic [7:0]   out_data, resp_number, alu_scalar, alu_number;
    logic         resp_valid, resp_overflow, resp_error, busy;
    logic [2:0]   alu_opcode, alu_matrix_size;
    logic [199:0] alu_A_flat, alu_B_flat, alu_C_flat;
    logic         alu_overflow_flag, alu_done;

    int           vectors = 0;
    int           miscompares = 0;
    logic [7:0]   sb [$];
    logic [7:0]   stim_a [25];
    logic [7:0]   stim_b [25];
    logic         det_mode = 1'b0;
    logic [7:0]   iss_cnt = 8'd0;
    logic [199:0] model_c;
    logic         model_ovf;
    int           cyc;
    logic         saw;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_matrix_size(cmd_matrix_size), .cmd_scalar(cmd_scalar),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .resp_valid(resp_valid), .resp_overflow(resp_overflow), .resp_error(resp_error),
        .resp_number(resp_number), .busy(busy),
        .alu_opcode(alu_opcode), .alu_matrix_size(alu_matrix_size),
        .alu_A_flat(alu_A_flat), .alu_B_flat(alu_B_flat), .alu_scalar(alu_scalar),
        .alu_C_flat(alu_C_flat), .alu_number(alu_number),
        .alu_overflow_flag(alu_overflow_flag), .alu_done(alu_done)
    );

    // Behavioural ALU: results only become visible two cycles after issue.
    always @(posedge clock) begin
        if (alu_opcode == 3'd0) iss_cnt <= 8'd0;
        else if (iss_cnt != 8'hff) iss_cnt <= iss_cnt + 8'd1;
    end

    always_comb begin
        logic signed [7:0]  a, b;
        logic signed [8:0]  s;
        logic signed [15:0] p;
        model_c   = '0;
        model_ovf = 1'b0;
        a = '0; b = '0; s = '0; p = '0;
        for (int k = 0; k < 25; k++) begin
            a = alu_A_flat[8*k +: 8];
            b = alu_B_flat[8*k +: 8];
            if (alu_opcode == 3'd1) begin
                s = a + b;
                model_c[8*k +: 8] = s[7:0];
                if (s > 127 || s < -128) model_ovf = 1'b1;
            end else if (alu_opcode == 3'd6) begin
                p = a * $signed(alu_scalar);
                model_c[8*k +: 8] = p[7:0];
                if (p > 127 || p < -128) model_ovf = 1'b1;
            end
        end
    end

    assign alu_C_flat        = (iss_cnt >= 8'd2) ? model_c : '0;
    assign alu_overflow_flag = (iss_cnt >= 8'd2) ? model_ovf : 1'b0;
    assign alu_done          = det_mode && (alu_opcode == 3'd7) && (iss_cnt >= 8'd10);
    assign alu_number        = 8'h05;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [2:0] n, input logic [7:0] sc);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_matrix_size = n; cmd_scalar = sc;
        chk_bit("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk_bit("in_ready_timeout", in_ready, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int nbeats, input logic [3:0] pat);
        int         got = 0;
        int         c = 0;
        int         pi = 0;
        logic       stalled = 1'b0;
        logic [7:0] held = 8'd0;
        logic [7:0] exp;
        while (got < nbeats && c < 200) begin
            out_ready = out_valid ? pat[pi % 4] : 1'b1;
            if (out_valid) begin
                pi++;
                if (stalled) chk_byte("stall_hold", out_data, held);
                if (out_ready) begin
                    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                    chk_byte("out_data", out_data, exp);
                    chk_bit("out_last", out_last, got == nbeats - 1);
                    got++;
                    stalled = 1'b0;
                end else begin
                    held    = out_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clock);
            c++;
        end
        out_ready = 1'b0;
        chk_int("stream_beats", got, nbeats);
        chk_int("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic wait_resp(input int budget, input logic eo, input logic ee, input logic [7:0] en,
                             output int cycles, output logic saw_out);
        int c = 0;
        saw_out = 1'b0;
        while (!resp_valid && c < budget) begin
            saw_out |= out_valid;
            @(negedge clock);
            c++;
        end
        cycles = c;
        chk_bit("resp_valid", resp_valid, 1'b1);
        chk_bit("resp_overflow", resp_overflow, eo);
        chk_bit("resp_error", resp_error, ee);
        chk_byte("resp_number", resp_number, en);
        @(negedge clock);
        chk_bit("resp_one_cycle", resp_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cmd_opcode = 3'd0; cmd_matrix_size = 3'd0; cmd_scalar = 8'd0; in_data = 8'd0;
        repeat (3) @(negedge clock);
        chk_bit("rst_cmd_ready", cmd_ready, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_resp_valid", resp_valid, 1'b0);
        chk_byte("rst_alu_opcode", {5'd0, alu_opcode}, 8'd0);
        reset = 1'b0;
        @(negedge clock);

        // Sum, n=2
        stim_a[0:3] = '{8'd1, 8'd2, 8'd3, 8'd4};
        stim_b[0:3] = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int i = 0; i < 4; i++) sb.push_back(stim_a[i] + stim_b[i]);
        send_cmd(3'd1, 3'd2, 8'd0);
        chk_bit("sum_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(stim_a[i]);
        chk_byte("sum_A_byte0", alu_A_flat[7:0], 8'd1);
        chk_byte("sum_A_byte1", alu_A_flat[15:8], 8'd2);
        chk_byte("sum_A_byte5", alu_A_flat[47:40], 8'd3);
        chk_byte("sum_A_byte6", alu_A_flat[55:48], 8'd4);
        chk_byte("sum_A_byte2", alu_A_flat[23:16], 8'd0);
        chk_bit("sum_in_ready_B", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(stim_b[i]);
        chk_byte("sum_B_byte6", alu_B_flat[55:48], 8'd40);
        drain(4, 4'b1111);
        wait_resp(5, 1'b0, 1'b0, 8'd0, cyc, saw);
        chk_byte("idle_alu_opcode", {5'd0, alu_opcode}, 8'd0);

        // Scalar, n=3, one element overflows
        stim_a[0:8] = '{8'd1, 8'd2, 8'd3, 8'd100, 8'hfc, 8'd5, 8'd6, 8'd7, 8'd8};
        for (int i = 0; i < 9; i++) sb.push_back(8'(stim_a[i] * 8'd2));
        send_cmd(3'd6, 3'd3, 8'd2);
        for (int i = 0; i < 9; i++) send_beat(stim_a[i]);
        chk_bit("scl_in_ready_low", in_ready, 1'b0);
        chk_byte("scl_alu_opcode", {5'd0, alu_opcode}, 8'd6);
        drain(9, 4'b1111);
        wait_resp(5, 1'b1, 1'b0, 8'd0, cyc, saw);
        chk_bit("flags_held_idle", resp_overflow, 1'b1);

        // Determinant, n=3, ALU done 10 cycles after issue
        det_mode = 1'b1;
        send_cmd(3'd7, 3'd3, 8'd0);
        for (int i = 0; i < 9; i++) send_beat(8'(i + 1));
        wait_resp(100, 1'b0, 1'b0, 8'h05, cyc, saw);
        chk_int("det_done_cycles", cyc, 11);
        chk_bit("det_no_output", saw, 1'b0);

        // Determinant timeout
        det_mode = 1'b0;
        send_cmd(3'd7, 3'd3, 8'd0);
        for (int i = 0; i < 9; i++) send_beat(8'(i + 1));
        wait_resp(100, 1'b0, 1'b1, 8'h00, cyc, saw);
        chk_int("det_timeout_cycles", cyc, 65);

        // Backpressure on a sum with overflow
        stim_a[0:3] = '{8'd100, 8'hff, 8'd7, 8'd8};
        stim_b[0:3] = '{8'd100, 8'd1, 8'd9, 8'd10};
        for (int i = 0; i < 4; i++) sb.push_back(stim_a[i] + stim_b[i]);
        send_cmd(3'd1, 3'd2, 8'd0);
        for (int i = 0; i < 4; i++) send_beat(stim_a[i]);
        for (int i = 0; i < 4; i++) send_beat(stim_b[i]);
        drain(4, 4'b1001);
        wait_resp(5, 1'b1, 1'b0, 8'd0, cyc, saw);

        // Illegal size and illegal opcode
        send_cmd(3'd1, 3'd6, 8'd0);
        chk_bit("bad_size_in_ready", in_ready, 1'b0);
        wait_resp(2, 1'b0, 1'b1, 8'd0, cyc, saw);
        send_cmd(3'd0, 3'd3, 8'd0);
        chk_bit("bad_op_in_ready", in_ready, 1'b0);
        wait_resp(2, 1'b0, 1'b1, 8'd0, cyc, saw);

        // Reset in the middle of LOAD_B
        send_cmd(3'd1, 3'd2, 8'd0);
        for (int i = 0; i < 4; i++) send_beat(8'(i + 9));
        send_beat(8'd55);
        chk_bit("pre_rst_in_ready", in_ready, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk_bit("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk_bit("mid_rst_busy", busy, 1'b0);
        chk_bit("mid_rst_A_clear", |alu_A_flat, 1'b0);
        chk_bit("mid_rst_B_clear", |alu_B_flat, 1'b0);
        chk_bit("mid_rst_resp", resp_valid, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_bit("post_rst_no_resp", resp_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
